pwm_ctrl_regs: RTL and testbench

Avalon-MM slave that owns the frequency and duty selector codes driven into the PWM generator (`fre[1:0]`, `duty[2:0]`). It sits directly upstream of the PWM counter and is written by the Nios II over the system interconnect. Duty changes either apply immediately or soft-ramp one code step per programmable interval, and an interrupt signals ramp completion.

---
 rtl/pwm_pkg.sv | 38 +++
 rtl/pwm_step_timer.sv | 29 ++
 rtl/pwm_ctrl_regs.sv | 168 ++++++++++++++++
 tb/tb_pwm_ctrl_regs.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM control register block: duty codes,
// register map, control/status bit positions and the ramp FSM state type.
package pwm_pkg;

    // Duty selector codes understood by the PWM generator
    localparam logic [2:0] DUTY_100 = 3'd0;
    localparam logic [2:0] DUTY_80  = 3'd1;
    localparam logic [2:0] DUTY_50  = 3'd2;
    localparam logic [2:0] DUTY_25  = 3'd3;
    localparam logic [2:0] DUTY_10  = 3'd4;
    localparam logic [2:0] DUTY_0   = 3'd5;

    // Word offsets of the register map
    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_CFG    = 2'd1;
    localparam logic [1:0] ADDR_STEP   = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    // CTRL bit positions
    localparam int CTRL_ENABLE_BIT  = 0;
    localparam int CTRL_RAMP_EN_BIT = 1;
    localparam int CTRL_IRQ_EN_BIT  = 2;

    // STATUS bit positions
    localparam int STATUS_BUSY_BIT = 0;
    localparam int STATUS_DONE_BIT = 1;

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } ramp_state_t;

    // Codes above 0 % duty have no meaning to the generator; fold them to 0 %.
    function automatic logic [2:0] clamp_duty(input logic [2:0] code);
        return (code > DUTY_0) ? DUTY_0 : code;
    endfunction

endpackage

// File: rtl/pwm_step_timer.sv
// Loadable 16-bit down-counter that paces the duty ramp. An interval of 0
// is treated as 1 so the ramp can never stall.
module pwm_step_timer (
    input  logic        iClk,
    input  logic        iReset_n,
    input  logic        load,
    input  logic        run,
    input  logic [15:0] interval,
    output logic        expire
);

    logic [15:0] count_reg;
    logic [15:0] reload_val;

    assign reload_val = (interval == 16'd0) ? 16'd1 : interval;
    assign expire     = run && (count_reg <= 16'd1);

    // Reload on start or on every expiry, otherwise count down while running
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            count_reg <= 16'd1;
        end else if (load || expire) begin
            count_reg <= reload_val;
        end else if (run) begin
            count_reg <= count_reg - 16'd1;
        end
    end

endmodule

// File: rtl/pwm_ctrl_regs.sv
// Avalon-MM register block driving the PWM generator's fre/duty selectors,
// with optional soft-ramping of the duty code and a completion interrupt.
module pwm_ctrl_regs
    import pwm_pkg::*;
#(
    parameter logic [15:0] STEP_RESET = 16'd1000
) (
    input  logic        iClk,
    input  logic        iReset_n,
    input  logic        avs_chipselect,
    input  logic [1:0]  avs_address,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    input  logic        avs_read,
    output logic [31:0] avs_readdata,
    output logic [1:0]  fre,
    output logic [2:0]  duty,
    output logic        ramp_busy,
    output logic        irq
);

    logic        wr_ctrl, wr_cfg, wr_step, wr_status, rd_en;
    logic        ctrl_en_reg, ramp_en_reg, irq_en_reg;
    logic [1:0]  tgt_fre_reg;
    logic [2:0]  tgt_duty_reg;
    logic [15:0] step_reg;
    ramp_state_t state_reg;
    logic [2:0]  cur_duty_reg;
    logic        done_reg, irq_reg;
    logic [31:0] readdata_reg, rd_mux;

    logic        en_next, ramp_en_eff, start, done_set, done_clr;
    logic        timer_load, timer_run, timer_expire;
    logic [2:0]  start_target, step_duty;
    logic        unused_wdata;

    assign wr_ctrl   = avs_chipselect && avs_write && (avs_address == ADDR_CTRL);
    assign wr_cfg    = avs_chipselect && avs_write && (avs_address == ADDR_CFG);
    assign wr_step   = avs_chipselect && avs_write && (avs_address == ADDR_STEP);
    assign wr_status = avs_chipselect && avs_write && (avs_address == ADDR_STATUS);
    assign rd_en     = avs_chipselect && avs_read;

    // Bits with no register behind them
    assign unused_wdata = ^{avs_writedata[31:16], avs_writedata[7], avs_writedata[3]};

    // Configuration registers written by software
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            ctrl_en_reg  <= 1'b0;
            ramp_en_reg  <= 1'b0;
            irq_en_reg   <= 1'b0;
            tgt_fre_reg  <= 2'd0;
            tgt_duty_reg <= DUTY_0;
            step_reg     <= STEP_RESET;
        end else begin
            if (wr_ctrl) begin
                ctrl_en_reg <= avs_writedata[CTRL_ENABLE_BIT];
                ramp_en_reg <= avs_writedata[CTRL_RAMP_EN_BIT];
                irq_en_reg  <= avs_writedata[CTRL_IRQ_EN_BIT];
            end
            if (wr_cfg) begin
                tgt_fre_reg  <= avs_writedata[1:0];
                tgt_duty_reg <= clamp_duty(avs_writedata[6:4]);
            end
            if (wr_step) begin
                step_reg <= avs_writedata[15:0];
            end
        end
    end

    // Decide what the FSM does this cycle; CTRL writes act on the edge they occur
    always_comb begin
        en_next      = wr_ctrl ? avs_writedata[CTRL_ENABLE_BIT] : ctrl_en_reg;
        ramp_en_eff  = wr_ctrl ? avs_writedata[CTRL_RAMP_EN_BIT] : ramp_en_reg;
        start        = (wr_cfg && ctrl_en_reg) ||
                       (wr_ctrl && avs_writedata[CTRL_ENABLE_BIT] && !ctrl_en_reg);
        start_target = wr_cfg ? clamp_duty(avs_writedata[6:4]) : tgt_duty_reg;
        step_duty    = (tgt_duty_reg > cur_duty_reg) ? cur_duty_reg + 3'd1
                                                     : cur_duty_reg - 3'd1;
        done_clr     = wr_status && avs_writedata[STATUS_DONE_BIT];
        timer_load   = (state_reg == IDLE) && en_next && start &&
                       (start_target != cur_duty_reg) && ramp_en_eff;
        timer_run    = (state_reg == RAMP);
        done_set     = 1'b0;
        if (en_next) begin
            if (state_reg == IDLE) begin
                done_set = start && ((start_target == cur_duty_reg) || !ramp_en_eff);
            end else begin
                done_set = (cur_duty_reg == tgt_duty_reg);
            end
        end
    end

    pwm_step_timer u_step_timer (
        .iClk     (iClk),
        .iReset_n (iReset_n),
        .load     (timer_load),
        .run      (timer_run),
        .interval (step_reg),
        .expire   (timer_expire)
    );

    // Ramp FSM: current duty, sticky done flag and the registered interrupt
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            state_reg    <= IDLE;
            cur_duty_reg <= DUTY_0;
            done_reg     <= 1'b0;
            irq_reg      <= 1'b0;
        end else begin
            irq_reg  <= done_reg & irq_en_reg;
            done_reg <= done_set | (done_reg & ~done_clr);
            if (!en_next) begin
                state_reg    <= IDLE;
                cur_duty_reg <= DUTY_0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (start) begin
                            if (timer_load) begin
                                state_reg <= RAMP;
                            end else begin
                                cur_duty_reg <= start_target;
                            end
                        end
                    end
                    RAMP: begin
                        if (cur_duty_reg == tgt_duty_reg) begin
                            state_reg <= IDLE;
                        end else if (timer_expire) begin
                            cur_duty_reg <= step_duty;
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

    // Read multiplexer
    always_comb begin
        rd_mux = 32'd0;
        case (avs_address)
            ADDR_CTRL:   rd_mux = {29'd0, irq_en_reg, ramp_en_reg, ctrl_en_reg};
            ADDR_CFG:    rd_mux = {25'd0, tgt_duty_reg, 2'b00, tgt_fre_reg};
            ADDR_STEP:   rd_mux = {16'd0, step_reg};
            ADDR_STATUS: rd_mux = {22'd0, tgt_fre_reg, 1'b0, cur_duty_reg, 2'b00,
                                   done_reg, (state_reg == RAMP)};
            default:     rd_mux = 32'd0;
        endcase
    end

    // Registered read data, held between reads
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            readdata_reg <= 32'd0;
        end else if (rd_en) begin
            readdata_reg <= rd_mux;
        end
    end

    assign avs_readdata = readdata_reg;
    assign fre          = tgt_fre_reg;
    assign duty         = cur_duty_reg;
    assign ramp_busy    = (state_reg == RAMP);
    assign irq          = irq_reg;

endmodule

// File: tb/tb_pwm_ctrl_regs.sv
// Self-checking bench for pwm_ctrl_regs: directed scenarios plus randomized
// immediate updates and ramps checked against a timing-formula reference.
module tb_pwm_ctrl_regs;

    logic        iClk = 1'b0;
    logic        iReset_n = 1'b0;
    logic        avs_chipselect = 1'b0;
    logic [1:0]  avs_address = 2'd0;
    logic        avs_write = 1'b0;
    logic [31:0] avs_writedata = 32'd0;
    logic        avs_read = 1'b0;
    logic [31:0] avs_readdata;
    logic [1:0]  fre;
    logic [2:0]  duty;
    logic        ramp_busy;
    logic        irq;

    int checks = 0;
    int errors = 0;
    int m_cur  = 5;   // reference: duty code currently applied
    int m_fre  = 0;   // reference: frequency code currently applied

    pwm_ctrl_regs #(.STEP_RESET(16'd1000)) dut (
        .iClk           (iClk),
        .iReset_n       (iReset_n),
        .avs_chipselect (avs_chipselect),
        .avs_address    (avs_address),
        .avs_write      (avs_write),
        .avs_writedata  (avs_writedata),
        .avs_read       (avs_read),
        .avs_readdata   (avs_readdata),
        .fre            (fre),
        .duty           (duty),
        .ramp_busy      (ramp_busy),
        .irq            (irq)
    );

    always #5 iClk = ~iClk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic int clampd(input int c);
        return (c > 5) ? 5 : c;
    endfunction

    // Called at a negedge; write captured on the next posedge, returns at the following negedge
    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        avs_chipselect = 1'b1; avs_write = 1'b1; avs_address = a; avs_writedata = d;
        @(negedge iClk);
        avs_chipselect = 1'b0; avs_write = 1'b0; avs_writedata = $urandom();
        $display("WR addr=%0d data=0x%08h", a, d);
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        avs_chipselect = 1'b1; avs_read = 1'b1; avs_address = a;
        @(negedge iClk);
        avs_chipselect = 1'b0; avs_read = 1'b0;
        d = avs_readdata;
        $display("RD addr=%0d data=0x%08h", a, d);
    endtask

    // Follows a ramp started by the write that just returned (k = 0 is that edge)
    task automatic ramp_follow(input int start, input int tgt, input int s, input bit ie);
        int n, dir, last, irq_k, kmax, steps;
        logic [2:0] exp_d;
        logic exp_b, exp_i;
        n     = (tgt > start) ? tgt - start : start - tgt;
        dir   = (tgt > start) ? 1 : -1;
        last  = n * s;
        irq_k = (n == 0) ? 1 : last + 2;
        kmax  = irq_k;
        for (int k = 0; k <= kmax; k++) begin
            if (k > 0) @(negedge iClk);
            steps = (k / s > n) ? n : k / s;
            exp_d = 3'(start + dir * steps);
            exp_b = (n > 0) && (k <= last);
            exp_i = ie && (k >= irq_k);
            checks++;
            if (duty !== exp_d) begin
                errors++;
                $display("FAIL ramp_duty k=%0d: got %0d expected %0d", k, duty, exp_d);
            end
            checks++;
            if (ramp_busy !== exp_b) begin
                errors++;
                $display("FAIL ramp_busy k=%0d: got %0b expected %0b", k, ramp_busy, exp_b);
            end
            checks++;
            if (irq !== exp_i) begin
                errors++;
                $display("FAIL ramp_irq k=%0d: got %0b expected %0b", k, irq, exp_i);
            end
        end
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        logic [31:0] exp [4];
        exp[0] = 32'h0; exp[1] = 32'h50; exp[2] = 32'd1000; exp[3] = 32'h50;
        for (int a = 0; a < 4; a++) begin
            bus_read(2'(a), rd);
            checks++;
            if (rd !== exp[a]) begin
                errors++;
                $display("FAIL reset_reg%0d: got 0x%0h expected 0x%0h", a, rd, exp[a]);
            end
        end
        checks++;
        if (duty !== 3'd5 || fre !== 2'd0 || irq !== 1'b0 || ramp_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got duty=%0d fre=%0d irq=%0b busy=%0b expected 5/0/0/0",
                     duty, fre, irq, ramp_busy);
        end
    endtask

    task automatic test_immediate();
        logic [31:0] rd, w;
        int ed, ef;
        bus_write(2'd0, 32'h1);
        bus_write(2'd1, 32'h01);
        m_cur = 0; m_fre = 1;
        checks++;
        if (fre !== 2'd1 || duty !== 3'd0) begin
            errors++;
            $display("FAIL imm_first: got fre=%0d duty=%0d expected 1/0", fre, duty);
        end
        bus_read(2'd3, rd);
        checks++;
        if (rd !== 32'h102) begin
            errors++;
            $display("FAIL imm_status: got 0x%0h expected 0x102", rd);
        end
        for (int i = 0; i < 8; i++) begin
            w  = $urandom();
            ed = clampd(int'(w[6:4]));
            ef = int'(w[1:0]);
            bus_write(2'd1, w);
            m_cur = ed; m_fre = ef;
            checks++;
            if (duty !== 3'(ed) || fre !== 2'(ef)) begin
                errors++;
                $display("FAIL imm_rand%0d: got fre=%0d duty=%0d expected %0d/%0d",
                         i, fre, duty, ef, ed);
            end
            bus_read(2'd1, rd);
            checks++;
            if (rd !== 32'((ed << 4) | ef)) begin
                errors++;
                $display("FAIL imm_cfg_rb%0d: got 0x%0h expected 0x%0h", i, rd, (ed << 4) | ef);
            end
            checks++;
            if (irq !== 1'b0) begin
                errors++;
                $display("FAIL imm_irq%0d: got %0b expected 0", i, irq);
            end
        end
    endtask

    task automatic test_ramp_basic();
        logic [31:0] rd;
        bus_write(2'd3, 32'h2);
        bus_write(2'd0, 32'h0);
        m_cur = 5;
        bus_write(2'd2, 32'd4);
        bus_write(2'd1, 32'h00);
        m_fre = 0;
        checks++;
        if (duty !== 3'd5) begin
            errors++;
            $display("FAIL basic_disabled_duty: got %0d expected 5", duty);
        end
        bus_write(2'd0, 32'h7);
        ramp_follow(5, 0, 4, 1'b1);
        m_cur = 0;
        bus_read(2'd3, rd);
        checks++;
        if (rd !== 32'h02) begin
            errors++;
            $display("FAIL basic_status: got 0x%0h expected 0x2", rd);
        end
        bus_write(2'd3, 32'h2);
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL basic_irq_hold: got %0b expected 1", irq);
        end
        @(negedge iClk);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL basic_irq_clear: got %0b expected 0", irq);
        end
    endtask

    task automatic test_random_ramps();
        logic [31:0] rd;
        int s_raw, s_eff, t_raw, t, f;
        for (int i = 0; i < 5; i++) begin
            s_raw = $urandom_range(0, 4);
            s_eff = (s_raw == 0) ? 1 : s_raw;
            t_raw = $urandom_range(0, 7);
            t     = clampd(t_raw);
            f     = $urandom_range(0, 3);
            bus_write(2'd3, 32'h2);
            bus_write(2'd2, 32'(s_raw));
            bus_write(2'd1, 32'((t_raw << 4) | f));
            m_fre = f;
            checks++;
            if (fre !== 2'(f)) begin
                errors++;
                $display("FAIL rnd_fre%0d: got %0d expected %0d", i, fre, f);
            end
            ramp_follow(m_cur, t, s_eff, 1'b1);
            m_cur = t;
            bus_read(2'd3, rd);
            checks++;
            if (rd !== 32'((m_fre << 8) | (m_cur << 4) | 2)) begin
                errors++;
                $display("FAIL rnd_status%0d: got 0x%0h expected 0x%0h",
                         i, rd, (m_fre << 8) | (m_cur << 4) | 2);
            end
        end
    endtask

    task automatic test_retarget();
        logic [31:0] rd;
        logic [2:0] exp_d [4];
        logic       exp_b [4];
        bus_write(2'd3, 32'h2);
        bus_write(2'd0, 32'h0);
        bus_write(2'd2, 32'd4);
        bus_write(2'd1, 32'h00);
        m_fre = 0;
        bus_write(2'd0, 32'h7);
        for (int k = 1; k <= 9; k++) begin
            @(negedge iClk);
            checks++;
            if (duty !== 3'(5 - k / 4)) begin
                errors++;
                $display("FAIL retgt_pre k=%0d: got %0d expected %0d", k, duty, 5 - k / 4);
            end
        end
        bus_write(2'd1, 32'h40);
        exp_d[0] = 3'd3; exp_d[1] = 3'd3; exp_d[2] = 3'd4; exp_d[3] = 3'd4;
        exp_b[0] = 1'b1; exp_b[1] = 1'b1; exp_b[2] = 1'b1; exp_b[3] = 1'b0;
        for (int j = 0; j < 4; j++) begin
            if (j > 0) @(negedge iClk);
            checks++;
            if (duty !== exp_d[j] || ramp_busy !== exp_b[j]) begin
                errors++;
                $display("FAIL retgt_k%0d: got duty=%0d busy=%0b expected %0d/%0b",
                         10 + j, duty, ramp_busy, exp_d[j], exp_b[j]);
            end
        end
        m_cur = 4;
        bus_read(2'd3, rd);
        checks++;
        if (rd !== 32'h42) begin
            errors++;
            $display("FAIL retgt_status: got 0x%0h expected 0x42", rd);
        end
    endtask

    task automatic test_abort();
        logic [31:0] rd;
        bus_write(2'd3, 32'h2);
        bus_write(2'd1, 32'h00);
        for (int k = 1; k <= 5; k++) @(negedge iClk);
        checks++;
        if (duty !== 3'd3 || ramp_busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_pre: got duty=%0d busy=%0b expected 3/1", duty, ramp_busy);
        end
        bus_write(2'd0, 32'h0);
        m_cur = 5;
        checks++;
        if (duty !== 3'd5 || ramp_busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_out: got duty=%0d busy=%0b expected 5/0", duty, ramp_busy);
        end
        bus_read(2'd3, rd);
        checks++;
        if (rd !== 32'h50) begin
            errors++;
            $display("FAIL abort_status: got 0x%0h expected 0x50", rd);
        end
        bus_write(2'd1, 32'h73);
        m_fre = 3;
        bus_read(2'd1, rd);
        checks++;
        if (rd !== 32'h53 || duty !== 3'd5 || fre !== 2'd3) begin
            errors++;
            $display("FAIL abort_cfg7: got cfg=0x%0h duty=%0d fre=%0d expected 0x53/5/3",
                     rd, duty, fre);
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] rd;
        bus_write(2'd1, 32'h02);
        bus_write(2'd0, 32'h7);
        for (int k = 1; k <= 6; k++) @(negedge iClk);
        checks++;
        if (ramp_busy !== 1'b1 || duty !== 3'd4 || fre !== 2'd2) begin
            errors++;
            $display("FAIL areset_pre: got busy=%0b duty=%0d fre=%0d expected 1/4/2",
                     ramp_busy, duty, fre);
        end
        #2;
        iReset_n = 1'b0;
        #1;
        checks++;
        if (duty !== 3'd5 || fre !== 2'd0 || ramp_busy !== 1'b0 || irq !== 1'b0 ||
            avs_readdata !== 32'd0) begin
            errors++;
            $display("FAIL areset_out: got duty=%0d fre=%0d busy=%0b irq=%0b rd=0x%0h expected 5/0/0/0/0",
                     duty, fre, ramp_busy, irq, avs_readdata);
        end
        @(negedge iClk);
        iReset_n = 1'b1;
        m_cur = 5; m_fre = 0;
        bus_read(2'd3, rd);
        checks++;
        if (rd !== 32'h50) begin
            errors++;
            $display("FAIL areset_status: got 0x%0h expected 0x50", rd);
        end
        bus_read(2'd0, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL areset_ctrl: got 0x%0h expected 0x0", rd);
        end
    endtask

    initial begin
        iReset_n = 1'b0;
        repeat (3) @(negedge iClk);
        iReset_n = 1'b1;
        @(negedge iClk);
        test_reset();
        test_immediate();
        test_ramp_basic();
        test_random_ramps();
        test_retarget();
        test_abort();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
